// File: rtl/game_pkg.sv
// Shared game/HID definitions: report layout, usage codes and parser state encoding.
package game_pkg;

    localparam int unsigned REPORT_BYTES        = 8;
    localparam int unsigned TIMEOUT_CYCLES_DFLT = 50000;
    localparam int unsigned IDX_W               = 3;
    localparam int unsigned MOD_IDX             = 0;
    localparam int unsigned KEY0_IDX            = 2;
    localparam int unsigned KEY_CNT             = 4;

    localparam logic [7:0] ROLLOVER_CODE = 8'h01;
    localparam logic [7:0] KEY_W         = 8'h1A;
    localparam logic [7:0] KEY_S         = 8'h16;
    localparam logic [7:0] KEY_O         = 8'h12;
    localparam logic [7:0] KEY_L         = 8'h0F;

    typedef enum logic [1:0] {
        PS_IDLE    = 2'd0,
        PS_COLLECT = 2'd1,
        PS_COMMIT  = 2'd2
    } parser_state_t;

    // Byte i of the boot report lives in element [i].
    typedef logic [REPORT_BYTES-1:0][7:0] hid_report_t;

    // True when every usage slot carries ErrorRollOver.
    function automatic logic is_rollover(input hid_report_t r);
        logic all_ro;
        all_ro = 1'b1;
        for (int unsigned i = KEY0_IDX; i < REPORT_BYTES; i++) begin
            all_ro = all_ro & (r[IDX_W'(i)] == ROLLOVER_CODE);
        end
        return all_ro;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/hid_byte_timeout.sv
// Inter-byte watchdog: reloads on load, counts down while enabled, flags expiry on the last cycle.
module hid_byte_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic load,
    input  logic enable,
    output logic expire_c
);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(TIMEOUT_CYCLES - 1);
        end else if (enable && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    // Expires after TIMEOUT_CYCLES consecutive idle cycles following a load.
    assign expire_c = enable && !load && (count == '0);

endmodule

// File: rtl/hid_keycode_parser.sv
// Parses HID boot-protocol keyboard reports into an atomically updated keycode/modifier pair.
module hid_keycode_parser
    import game_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        sof,
    output logic        byte_ready,
    output logic [31:0] keycode,
    output logic [7:0]  modifiers,
    output logic        valid,
    output logic        key_change,
    output logic        rollover_err,
    output logic [7:0]  drop_count
);
    parser_state_t    state, state_d;
    logic [IDX_W-1:0] index, index_d;
    hid_report_t      shadow, shadow_d;
    logic [31:0]      keycode_d;
    logic [7:0]       modifiers_d;
    logic             valid_d;
    logic             key_change_d;
    logic             rollover_err_d;
    logic [7:0]       drop_count_d;

    logic        xfer_c;
    logic        timeout_c;
    logic [31:0] shadow_keys_c;

    assign byte_ready    = (state != PS_COMMIT);
    assign xfer_c        = byte_valid && byte_ready;
    assign shadow_keys_c = shadow[KEY0_IDX+KEY_CNT-1:KEY0_IDX];

    hid_byte_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .load    (xfer_c),
        .enable  (state == PS_COLLECT),
        .expire_c(timeout_c)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= PS_IDLE;
            index        <= '0;
            shadow       <= '0;
            keycode      <= '0;
            modifiers    <= '0;
            valid        <= 1'b0;
            key_change   <= 1'b0;
            rollover_err <= 1'b0;
            drop_count   <= '0;
        end else begin
            state        <= state_d;
            index        <= index_d;
            shadow       <= shadow_d;
            keycode      <= keycode_d;
            modifiers    <= modifiers_d;
            valid        <= valid_d;
            key_change   <= key_change_d;
            rollover_err <= rollover_err_d;
            drop_count   <= drop_count_d;
        end
    end

    always_comb begin
        state_d        = state;
        index_d        = index;
        shadow_d       = shadow;
        keycode_d      = keycode;
        modifiers_d    = modifiers;
        valid_d        = valid;
        key_change_d   = 1'b0;
        rollover_err_d = rollover_err;
        drop_count_d   = drop_count;

        case (state)
            PS_IDLE: begin
                // Non-sof bytes here belong to no report and are silently consumed.
                if (xfer_c && sof) begin
                    shadow_d                  = '0;
                    shadow_d[IDX_W'(MOD_IDX)] = byte_in;
                    index_d                   = IDX_W'(1);
                    state_d                   = PS_COLLECT;
                end
            end
            PS_COLLECT: begin
                if (xfer_c && sof) begin
                    drop_count_d              = sat_inc8(drop_count);
                    shadow_d                  = '0;
                    shadow_d[IDX_W'(MOD_IDX)] = byte_in;
                    index_d                   = IDX_W'(1);
                end else if (xfer_c) begin
                    shadow_d[index] = byte_in;
                    index_d         = index + IDX_W'(1);
                    if (index == IDX_W'(REPORT_BYTES - 1)) begin
                        state_d = PS_COMMIT;
                    end
                end else if (timeout_c) begin
                    drop_count_d = sat_inc8(drop_count);
                    index_d      = '0;
                    state_d      = PS_IDLE;
                end
            end
            PS_COMMIT: begin
                state_d = PS_IDLE;
                index_d = '0;
                if (is_rollover(shadow)) begin
                    rollover_err_d = 1'b1;
                end else begin
                    keycode_d      = shadow_keys_c;
                    modifiers_d    = shadow[IDX_W'(MOD_IDX)];
                    rollover_err_d = 1'b0;
                    valid_d        = 1'b1;
                    key_change_d   = (shadow_keys_c != keycode);
                end
            end
            default: begin
                state_d = PS_IDLE;
                index_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_hid_keycode_parser.sv
// Randomized bench for hid_keycode_parser against a queue-based report model, plus pinned literal checks.
module tb_hid_keycode_parser;
    import game_pkg::*;

    localparam int unsigned TB_TO = 24;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        sof = 1'b0;
    logic        byte_ready;
    logic [31:0] keycode;
    logic [7:0]  modifiers;
    logic        valid;
    logic        key_change;
    logic        rollover_err;
    logic [7:0]  drop_count;

    int total = 0;
    int bad   = 0;

    hid_keycode_parser #(
        .TIMEOUT_CYCLES(TB_TO)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .sof         (sof),
        .byte_ready  (byte_ready),
        .keycode     (keycode),
        .modifiers   (modifiers),
        .valid       (valid),
        .key_change  (key_change),
        .rollover_err(rollover_err),
        .drop_count  (drop_count)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: bytes of the report in progress, idle-cycle count, and expected outputs.
    logic [7:0]  m_q[$];
    bit          m_in, m_commit;
    int          m_idle;
    logic [31:0] e_key, m_nk;
    logic [7:0]  e_mod, e_drop;
    bit          e_valid, e_kc, e_roll, e_ready, m_ro;

    initial forever begin
        @(posedge Clk or negedge Reset_n);
        if (!Reset_n) begin
            m_q.delete();
            m_in = 0; m_commit = 0; m_idle = 0;
            e_key = '0; e_mod = '0; e_drop = '0;
            e_valid = 0; e_kc = 0; e_roll = 0; e_ready = 1;
        end else begin
            e_kc = 0;
            if (m_commit) begin
                m_ro = 1;
                for (int i = 2; i < 8; i++) if (m_q[i] != ROLLOVER_CODE) m_ro = 0;
                m_nk = {m_q[5], m_q[4], m_q[3], m_q[2]};
                if (m_ro) e_roll = 1;
                else begin
                    e_kc = (m_nk != e_key);
                    e_key = m_nk; e_mod = m_q[0]; e_roll = 0; e_valid = 1;
                end
                m_commit = 0; m_in = 0; m_q.delete();
            end else if (byte_valid) begin
                if (sof) begin
                    if (m_in && e_drop != 8'hFF) e_drop = e_drop + 8'd1;
                    m_q.delete(); m_q.push_back(byte_in);
                    m_in = 1; m_idle = 0;
                end else if (m_in) begin
                    m_q.push_back(byte_in); m_idle = 0;
                    if (m_q.size() == 8) m_commit = 1;
                end
            end else if (m_in) begin
                m_idle++;
                if (m_idle == TB_TO) begin
                    m_in = 0; m_q.delete();
                    if (e_drop != 8'hFF) e_drop = e_drop + 8'd1;
                end
            end
            e_ready = !m_commit;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge Clk);
        if (Reset_n) begin
            chk("byte_ready", 32'(byte_ready), 32'(e_ready));
            chk("keycode", keycode, e_key);
            chk("modifiers", 32'(modifiers), 32'(e_mod));
            chk("valid", 32'(valid), 32'(e_valid));
            chk("key_change", 32'(key_change), 32'(e_kc));
            chk("rollover_err", 32'(rollover_err), 32'(e_roll));
            chk("drop_count", 32'(drop_count), 32'(e_drop));
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit s);
        int guard;
        guard = 0;
        @(negedge Clk);
        byte_valid = 1'b1; byte_in = b; sof = s;
        while (!byte_ready && guard < 4) begin
            @(negedge Clk);
            guard++;
        end
        if (!byte_ready) begin
            total++; bad++;
            $display("FAIL handshake: byte_ready stuck at 0 at %0t", $time);
        end
    endtask

    task automatic idle(input int n);
        @(negedge Clk);
        byte_valid = 1'b0; sof = 1'b0; byte_in = 8'($urandom);
        repeat (n - 1) @(negedge Clk);
    endtask

    task automatic send_rep(input logic [63:0] r, input int len, input bit gaps);
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 11) == 0) idle(int'($urandom_range(1, TB_TO + 3)));
            send_byte(r[63 - 8*i -: 8], i == 0);
        end
    endtask

    function automatic logic [7:0] rand_key();
        case ($urandom_range(0, 5))
            0: return 8'h00;
            1: return KEY_W;
            2: return KEY_S;
            3: return KEY_O;
            4: return KEY_L;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        #900000;
        total++; bad++;
        $display("FAIL watchdog: run did not complete at %0t", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        logic [63:0] r, last_r;
        int kind, len, pos;

        repeat (3) @(negedge Clk);
        chk("rst_byte_ready", 32'(byte_ready), 32'd1);
        chk("rst_keycode", keycode, 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        Reset_n = 1'b1;

        // First report with byte_valid held: commit cycle then key_change.
        send_rep(64'h0000_1A16_0000_0000, 8, 0);
        @(negedge Clk); byte_valid = 1'b0;
        chk("commit_ready_low", 32'(byte_ready), 32'd0);
        chk("commit_kc_early", 32'(key_change), 32'd0);
        @(negedge Clk);
        chk("after_ready_high", 32'(byte_ready), 32'd1);
        chk("kc_pulse", 32'(key_change), 32'd1);
        chk("key1", keycode, 32'h0000161A);
        chk("mod1", 32'(modifiers), 32'd0);
        chk("valid1", 32'(valid), 32'd1);
        @(negedge Clk);
        chk("kc_single", 32'(key_change), 32'd0);

        // Identical report: no key_change.
        send_rep(64'h0000_1A16_0000_0000, 8, 0);
        idle(2);
        chk("same_kc", 32'(key_change), 32'd0);
        chk("same_key", keycode, 32'h0000161A);

        // Resync by a fresh sof after 4 bytes.
        send_rep(64'h0300_0404_0400_0000, 4, 0);
        send_rep(64'h0200_120F_0000_0000, 8, 0);
        idle(3);
        chk("resync_drop", 32'(drop_count), 32'd1);
        chk("resync_key", keycode, 32'h00000F12);
        chk("resync_mod", 32'(modifiers), 32'h02);

        // Rollover report leaves keycode, next normal report clears the flag.
        send_rep(64'h0000_0101_0101_0101, 8, 0);
        idle(3);
        chk("ro_flag", 32'(rollover_err), 32'd1);
        chk("ro_key", keycode, 32'h00000F12);
        chk("ro_mod", 32'(modifiers), 32'h02);
        send_rep(64'h0000_0400_0000_0000, 8, 0);
        idle(3);
        chk("ro_clear", 32'(rollover_err), 32'd0);
        chk("ro_clear_key", keycode, 32'h00000004);

        // Timeout abort; later non-sof bytes are ignored.
        send_rep(64'h0000_2C2C_0000_0000, 3, 0);
        idle(TB_TO + 3);
        chk("to_drop", 32'(drop_count), 32'd2);
        for (int i = 0; i < 5; i++) send_byte(8'h2C, 1'b0);
        idle(3);
        chk("to_key", keycode, 32'h00000004);
        chk("to_drop2", 32'(drop_count), 32'd2);

        // Gap of TB_TO-1 idle cycles survives.
        send_rep(64'h0000_2C00_0000_0000, 3, 0);
        idle(TB_TO - 1);
        for (int i = 3; i < 8; i++) send_byte(8'h00, 1'b0);
        idle(3);
        chk("gap_ok_key", keycode, 32'h0000002C);
        chk("gap_ok_drop", 32'(drop_count), 32'd2);

        // Reset mid-report clears everything asynchronously.
        send_rep(64'h0000_1A00_0000_0000, 3, 0);
        @(negedge Clk); byte_valid = 1'b0;
        #2 Reset_n = 1'b0;
        #1;
        chk("arst_key", keycode, 32'd0);
        chk("arst_valid", 32'(valid), 32'd0);
        chk("arst_drop", 32'(drop_count), 32'd0);
        chk("arst_ready", 32'(byte_ready), 32'd1);
        chk("arst_mod", 32'(modifiers), 32'd0);
        @(negedge Clk); Reset_n = 1'b1;
        send_rep(64'h0100_1A00_0000_0000, 8, 0);
        idle(3);
        chk("post_rst_key", keycode, 32'h0000001A);
        chk("post_rst_mod", 32'(modifiers), 32'h01);
        chk("post_rst_drop", 32'(drop_count), 32'd0);

        // Random traffic checked cycle by cycle by the model.
        last_r = '0;
        for (int n = 0; n < 400; n++) begin
            kind = int'($urandom_range(0, 9));
            r = {8'($urandom), 8'($urandom), rand_key(), rand_key(), rand_key(), rand_key(),
                 rand_key(), rand_key()};
            if (kind == 0) r[47:0] = 48'h0101_0101_0101;
            if (kind == 5) begin
                r[47:0] = 48'h0101_0101_0101;
                pos = int'($urandom_range(0, 5));
                r[8*pos +: 8] = 8'h00;
            end
            if (kind == 1) r = last_r;
            if (kind == 3) for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0);
            len = (kind == 2) ? int'($urandom_range(1, 7)) : 8;
            send_rep(r, len, 1);
            if (len == 8) last_r = r;
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 6)));
        end

        // Drop counter saturates.
        for (int i = 0; i < 270; i++) send_byte(8'($urandom), 1'b1);
        idle(3);
        chk("drop_sat", 32'(drop_count), 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
